xc_mask_remask_unit: RTL and testbench

- Sequential, parametrised remask engine for two-share masked operands. It supports two encodings, chosen per request:
  - Boolean: x = s0 ^ s1.
  - Arithmetic: x = (s0 - s1) mod 2^XLEN.
- Draws a fresh mask from an internal 64-bit Galois LFSR and returns a new share pair encoding the same x.
- Sits beside the masking ALU in the execute stage and replaces the single-cycle combinational arithmetic-only remask. Shares are updated in separate cycles, so unmasked x never forms on a wire.

---
 rtl/xc_mask_pkg.sv | 17 +
 rtl/xc_mask_lfsr64.sv | 26 ++
 rtl/xc_mask_remask_unit.sv | 98 +++++++++
 tb/tb_xc_mask_remask_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xc_mask_pkg.sv
// rtl/xc_mask_pkg.sv - shared constants and state type for the two-share remask engine
package xc_mask_pkg;

  localparam logic MODE_BOOL  = 1'b0;
  localparam logic MODE_ARITH = 1'b1;

  localparam logic [63:0] LFSR_POLY_DEFAULT  = 64'hD800000000000000;
  localparam logic [63:0] LFSR_RESET_DEFAULT = 64'h0000000000000001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UPD1,
    ST_UPD0,
    ST_RESP
  } remask_state_e;

endpackage

// File: rtl/xc_mask_lfsr64.sv
// rtl/xc_mask_lfsr64.sv - seedable 64-bit Galois LFSR supplying fresh masks
module xc_mask_lfsr64
  import xc_mask_pkg::*;
#(
  parameter logic [63:0] LFSR_POLY  = LFSR_POLY_DEFAULT,
  parameter logic [63:0] LFSR_RESET = LFSR_RESET_DEFAULT
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        seed_valid,
  input  logic [63:0] seed,
  output logic [63:0] state
);

  // An all-zero state would lock the register, so a zero seed falls back to the reset value.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state <= LFSR_RESET;
    end else if (seed_valid) begin
      state <= (seed == 64'd0) ? LFSR_RESET : seed;
    end else begin
      state <= (state >> 1) ^ (state[0] ? LFSR_POLY : 64'd0);
    end
  end

endmodule

// File: rtl/xc_mask_remask_unit.sv
// rtl/xc_mask_remask_unit.sv - sequential boolean/arithmetic remask of a two-share operand
module xc_mask_remask_unit
  import xc_mask_pkg::*;
#(
  parameter int          XLEN       = 32,
  parameter logic [63:0] LFSR_POLY  = LFSR_POLY_DEFAULT,
  parameter logic [63:0] LFSR_RESET = LFSR_RESET_DEFAULT
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            prng_seed_valid,
  input  logic [63:0]     prng_seed,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_mode,
  input  logic [XLEN-1:0] req_s0,
  input  logic [XLEN-1:0] req_s1,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_s0,
  output logic [XLEN-1:0] rsp_s1,
  output logic            busy
);

  remask_state_e   state;
  logic [XLEN-1:0] s0_q;
  logic [XLEN-1:0] s1_q;
  logic [XLEN-1:0] mask_q;
  logic            mode_q;
  logic [63:0]     lfsr_state;
  logic            lfsr_unused;

  xc_mask_lfsr64 #(
    .LFSR_POLY  (LFSR_POLY),
    .LFSR_RESET (LFSR_RESET)
  ) u_lfsr (
    .g_clk      (g_clk),
    .g_reset    (g_reset),
    .seed_valid (prng_seed_valid),
    .seed       (prng_seed),
    .state      (lfsr_state)
  );

  assign lfsr_unused = ^lfsr_state;

  assign rsp_s0 = s0_q;
  assign rsp_s1 = s1_q;

  // Shares are refreshed one per cycle so the unmasked value never appears combinationally.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state     <= ST_IDLE;
      s0_q      <= '0;
      s1_q      <= '0;
      mask_q    <= '0;
      mode_q    <= MODE_BOOL;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            s0_q      <= req_s0;
            s1_q      <= req_s1;
            mode_q    <= req_mode;
            mask_q    <= lfsr_state[XLEN-1:0];
            state     <= ST_UPD1;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_UPD1: begin
          s1_q  <= (mode_q == MODE_ARITH) ? (s1_q + mask_q) : (s1_q ^ mask_q);
          state <= ST_UPD0;
        end
        ST_UPD0: begin
          s0_q      <= (mode_q == MODE_ARITH) ? (s0_q + mask_q) : (s0_q ^ mask_q);
          state     <= ST_RESP;
          rsp_valid <= 1'b1;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            mask_q    <= '0;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xc_mask_remask_unit.sv
// tb/tb_xc_mask_remask_unit.sv - directed and randomized checks of the remask unit at XLEN 32 and 64
module tb_xc_mask_remask_unit;

  logic        g_clk = 1'b0;
  logic        g_reset = 1'b0;
  logic        prng_seed_valid = 1'b0;
  logic [63:0] prng_seed = 64'd0;

  logic        a_req_valid = 1'b0;
  logic        a_req_ready;
  logic        a_req_mode = 1'b0;
  logic [31:0] a_req_s0 = 32'd0;
  logic [31:0] a_req_s1 = 32'd0;
  logic        a_rsp_valid;
  logic        a_rsp_ready = 1'b1;
  logic [31:0] a_rsp_s0;
  logic [31:0] a_rsp_s1;
  logic        a_busy;

  logic        b_req_valid = 1'b0;
  logic        b_req_ready;
  logic        b_req_mode = 1'b0;
  logic [63:0] b_req_s0 = 64'd0;
  logic [63:0] b_req_s1 = 64'd0;
  logic        b_rsp_valid;
  logic        b_rsp_ready = 1'b1;
  logic [63:0] b_rsp_s0;
  logic [63:0] b_rsp_s1;
  logic        b_busy;

  int checks = 0;
  int errors = 0;

  always #5 g_clk = ~g_clk;

  xc_mask_remask_unit #(.XLEN(32)) dut_a (
    .g_clk           (g_clk),
    .g_reset         (g_reset),
    .prng_seed_valid (prng_seed_valid),
    .prng_seed       (prng_seed),
    .req_valid       (a_req_valid),
    .req_ready       (a_req_ready),
    .req_mode        (a_req_mode),
    .req_s0          (a_req_s0),
    .req_s1          (a_req_s1),
    .rsp_valid       (a_rsp_valid),
    .rsp_ready       (a_rsp_ready),
    .rsp_s0          (a_rsp_s0),
    .rsp_s1          (a_rsp_s1),
    .busy            (a_busy)
  );

  xc_mask_remask_unit #(.XLEN(64)) dut_b (
    .g_clk           (g_clk),
    .g_reset         (g_reset),
    .prng_seed_valid (prng_seed_valid),
    .prng_seed       (prng_seed),
    .req_valid       (b_req_valid),
    .req_ready       (b_req_ready),
    .req_mode        (b_req_mode),
    .req_s0          (b_req_s0),
    .req_s1          (b_req_s1),
    .rsp_valid       (b_rsp_valid),
    .rsp_ready       (b_rsp_ready),
    .rsp_s0          (b_rsp_s0),
    .rsp_s1          (b_rsp_s1),
    .busy            (b_busy)
  );

  task automatic tick;
    @(posedge g_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic seed_lfsr(input logic [63:0] s);
    prng_seed_valid = 1'b1;
    prng_seed = s;
    tick();
    prng_seed_valid = 1'b0;
  endtask

  task automatic a_accept(input logic md, input logic [31:0] s0, input logic [31:0] s1);
    a_req_valid = 1'b1;
    a_req_mode = md;
    a_req_s0 = s0;
    a_req_s1 = s1;
    tick();
    a_req_valid = 1'b0;
  endtask

  task automatic a_wait_rsp(input string tag);
    int n;
    n = 0;
    while (!a_rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk(tag, {63'd0, a_rsp_valid}, 64'd1);
  endtask

  initial begin
    #1 g_reset = 1'b1;
    #1;
    chk("rst_req_ready", {63'd0, a_req_ready}, 64'd1);
    chk("rst_rsp_valid", {63'd0, a_rsp_valid}, 64'd0);
    chk("rst_busy", {63'd0, a_busy}, 64'd0);
    chk("rst_rsp_s0", {32'd0, a_rsp_s0}, 64'd0);
    chk("rst_rsp_s1", {32'd0, a_rsp_s1}, 64'd0);
    chk("rst_b_req_ready", {63'd0, b_req_ready}, 64'd1);
    tick();
    tick();
    g_reset = 1'b0;

    // zero seed falls back to the reset value; mask with s1=0 exposes it
    seed_lfsr(64'd0);
    a_accept(1'b0, 32'd0, 32'd0);
    chk("busy_after_accept", {63'd0, a_busy}, 64'd1);
    chk("req_ready_after_accept", {63'd0, a_req_ready}, 64'd0);
    a_wait_rsp("zero_seed_timeout");
    chk("zero_seed_m", {32'd0, a_rsp_s1}, 64'd1);
    chk("zero_seed_s0", {32'd0, a_rsp_s0}, 64'd1);
    tick();
    chk("idle_req_ready", {63'd0, a_req_ready}, 64'd1);

    // seed then one step: both widths sample step(0x0123456789ABCDEF)
    seed_lfsr(64'h0123456789ABCDEF);
    tick();
    a_req_valid = 1'b1; a_req_mode = 1'b0; a_req_s0 = 32'd0; a_req_s1 = 32'd0;
    b_req_valid = 1'b1; b_req_mode = 1'b0; b_req_s0 = 64'd0; b_req_s1 = 64'd0;
    tick();
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    a_wait_rsp("step_timeout");
    chk("step_m32", {32'd0, a_rsp_s1}, 64'h00000000C4D5E6F7);
    chk("step_m64", b_rsp_s1, 64'hD891A2B3C4D5E6F7);
    tick();

    // boolean DEADBEEF with m = A5A5A5A5, exact three-cycle latency
    seed_lfsr(64'h00000000A5A5A5A5);
    a_accept(1'b0, 32'hDEADBEEF, 32'h0);
    chk("bool_lat_t0", {63'd0, a_rsp_valid}, 64'd0);
    tick();
    chk("bool_lat_t1", {63'd0, a_rsp_valid}, 64'd0);
    tick();
    chk("bool_lat_t2", {63'd0, a_rsp_valid}, 64'd1);
    chk("bool_s0", {32'd0, a_rsp_s0}, 64'h000000007B081B4A);
    chk("bool_s1", {32'd0, a_rsp_s1}, 64'h00000000A5A5A5A5);
    chk("bool_decode", {32'd0, a_rsp_s0 ^ a_rsp_s1}, 64'h00000000DEADBEEF);
    tick();

    // arithmetic wrap with m = FFFFFFFE; a seed mid-operation must not disturb m
    seed_lfsr(64'h00000000FFFFFFFE);
    a_accept(1'b1, 32'd5, 32'd3);
    seed_lfsr(64'h0000000011111111);
    a_wait_rsp("arith_timeout");
    chk("arith_s0", {32'd0, a_rsp_s0}, 64'd3);
    chk("arith_s1", {32'd0, a_rsp_s1}, 64'd1);
    chk("arith_diff", {32'd0, a_rsp_s0 - a_rsp_s1}, 64'd2);
    tick();

    // backpressure for 5 cycles with a competing request held high
    a_rsp_ready = 1'b0;
    seed_lfsr(64'h0000000012345678);
    a_accept(1'b1, 32'd100, 32'd40);
    a_wait_rsp("bp_timeout");
    a_req_valid = 1'b1; a_req_mode = 1'b0; a_req_s0 = 32'd7; a_req_s1 = 32'd2;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", {63'd0, a_rsp_valid}, 64'd1);
      chk("bp_s0", {32'd0, a_rsp_s0}, 64'h00000000123456DC);
      chk("bp_s1", {32'd0, a_rsp_s1}, 64'h00000000123456A0);
      chk("bp_req_ready", {63'd0, a_req_ready}, 64'd0);
      tick();
    end
    a_rsp_ready = 1'b1;
    tick();
    chk("bp_release_ready", {63'd0, a_req_ready}, 64'd1);
    chk("bp_release_busy", {63'd0, a_busy}, 64'd0);
    chk("bp_release_valid", {63'd0, a_rsp_valid}, 64'd0);
    tick();
    a_req_valid = 1'b0;
    chk("bp_next_accepted", {63'd0, a_busy}, 64'd1);
    a_wait_rsp("bp_next_timeout");
    chk("bp_next_decode", {32'd0, a_rsp_s0 ^ a_rsp_s1}, 64'd5);
    tick();

    // asynchronous reset while in UPD0
    a_accept(1'b1, 32'd9, 32'd4);
    tick();
    #2 g_reset = 1'b1;
    #1;
    chk("midrst_req_ready", {63'd0, a_req_ready}, 64'd1);
    chk("midrst_rsp_valid", {63'd0, a_rsp_valid}, 64'd0);
    chk("midrst_busy", {63'd0, a_busy}, 64'd0);
    chk("midrst_s0", {32'd0, a_rsp_s0}, 64'd0);
    g_reset = 1'b0;
    tick();
    seed_lfsr(64'h000000000F0F0F0F);
    a_accept(1'b0, 32'h11111111, 32'h22222222);
    a_wait_rsp("postrst_timeout");
    chk("postrst_s0", {32'd0, a_rsp_s0}, 64'h000000001E1E1E1E);
    chk("postrst_s1", {32'd0, a_rsp_s1}, 64'h000000002D2D2D2D);
    tick();

    // XLEN=64 random back-to-back regression with random backpressure
    for (int i = 0; i < 1000; i++) begin
      logic [63:0] s0;
      logic [63:0] s1;
      logic [63:0] exp_x;
      logic [63:0] got_x;
      logic        md;
      logic        done;
      int          n;
      s0 = {$urandom, $urandom};
      s1 = {$urandom, $urandom};
      md = 1'($urandom_range(0, 1));
      exp_x = md ? (s0 - s1) : (s0 ^ s1);
      b_req_valid = 1'b1; b_req_mode = md; b_req_s0 = s0; b_req_s1 = s1;
      n = 0;
      while (!b_req_ready && n < 50) begin
        tick();
        n++;
      end
      tick();
      b_req_valid = 1'b0;
      n = 0;
      done = 1'b0;
      while (!done && n < 200) begin
        b_rsp_ready = 1'($urandom_range(0, 1));
        if (b_rsp_valid && b_rsp_ready) begin
          got_x = md ? (b_rsp_s0 - b_rsp_s1) : (b_rsp_s0 ^ b_rsp_s1);
          chk("b_decode", got_x, exp_x);
          done = 1'b1;
        end
        tick();
        n++;
      end
      if (!done) chk("b_rsp_timeout", {63'd0, done}, 64'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
